// File: rtl/bdy_pkg.sv
// Shared constants for the AXI-Stream engine: command modes, FSM encoding and
// the widths of the packed FIFO entry {last, keep, data}.
package bdy_pkg;

    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int ENTRY_W = DATA_W + KEEP_W + 1;

    localparam logic [2:0] MODE_NONE  = 3'd0;
    localparam logic [2:0] MODE_COPY  = 3'd1;
    localparam logic [2:0] MODE_SWAP  = 3'd2;
    localparam logic [2:0] MODE_ACC   = 3'd3;
    localparam logic [2:0] MODE_CLEAR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ACC_OUT = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] swap_halves(input logic [DATA_W-1:0] d);
        return {d[31:0], d[63:32]};
    endfunction

endpackage

// File: rtl/bdy_axis_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy and a
// synchronous clear that empties it in one edge.
module bdy_axis_fifo #(
    parameter int WIDTH = 73,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(1 << AW);

    logic [WIDTH-1:0] r_mem [1 << AW];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;

    // Full is judged on the registered count only, so a full FIFO refuses a
    // write even when a pop happens on the same edge.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_do_wr = i_wr_en & ~w_full & ~i_clr;
    assign w_do_rd = i_rd_en & ~w_empty & ~i_clr;

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero when empty so stale or uninitialised storage never leaks out.
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/bdy_axis_engine.sv
// Stream engine: RX FIFO -> command datapath (copy / swap / accumulate) -> TX FIFO,
// with a strobe-started FSM and exported FIFO occupancies.
module bdy_axis_engine
    import bdy_pkg::*;
#(
    parameter int FIFO_AW = 5
) (
    input  logic        iSYS_CLK,
    input  logic        iSYS_RST,
    input  logic [2:0]  iCTL_START_MODE,
    input  logic        iS_AXIS_TVALID,
    output logic        oS_AXIS_TREADY,
    input  logic [63:0] iS_AXIS_TDATA,
    input  logic [7:0]  iS_AXIS_TKEEP,
    input  logic        iS_AXIS_TLAST,
    output logic        oM_AXIS_TVALID,
    input  logic        iM_AXIS_TREADY,
    output logic [63:0] oM_AXIS_TDATA,
    output logic [7:0]  oM_AXIS_TKEEP,
    output logic        oM_AXIS_TLAST,
    output logic [31:0] oR_AXIS_DCNT,
    output logic [31:0] oW_AXIS_DCNT,
    output logic [1:0]  oDBG_STATE
);

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_mode;
    logic [DATA_W-1:0]   r_acc;
    logic                r_rdy_en;

    logic                w_s_ready;
    logic                w_rx_wr;
    logic [ENTRY_W-1:0]  w_rx_rdata;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic [FIFO_AW:0]    w_rx_count;
    logic                w_rx_last;
    logic [KEEP_W-1:0]   w_rx_keep;
    logic [DATA_W-1:0]   w_rx_data;

    logic [ENTRY_W-1:0]  w_tx_rdata;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic [FIFO_AW:0]    w_tx_count;

    logic                w_rx_pop;
    logic                w_tx_push;
    logic [ENTRY_W-1:0]  w_tx_wdata;
    logic                w_fifo_clr;
    logic                w_acc_add;
    logic                w_start_run;

    // r_rdy_en keeps TREADY low through reset and for the rest of the release cycle.
    assign w_s_ready = r_rdy_en & ~w_rx_full & (r_state != ST_FLUSH);
    assign w_rx_wr   = iS_AXIS_TVALID & w_s_ready;

    assign w_rx_last = w_rx_rdata[ENTRY_W-1];
    assign w_rx_keep = w_rx_rdata[DATA_W +: KEEP_W];
    assign w_rx_data = w_rx_rdata[DATA_W-1:0];

    bdy_axis_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_rx_fifo (
        .i_clk     (iSYS_CLK),
        .i_rst_n   (iSYS_RST),
        .i_clr     (w_fifo_clr),
        .i_wr_en   (w_rx_wr),
        .i_wr_data ({iS_AXIS_TLAST, iS_AXIS_TKEEP, iS_AXIS_TDATA}),
        .i_rd_en   (w_rx_pop),
        .o_rd_data (w_rx_rdata),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_count   (w_rx_count)
    );

    bdy_axis_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .i_clk     (iSYS_CLK),
        .i_rst_n   (iSYS_RST),
        .i_clr     (w_fifo_clr),
        .i_wr_en   (w_tx_push),
        .i_wr_data (w_tx_wdata),
        .i_rd_en   (iM_AXIS_TREADY),
        .o_rd_data (w_tx_rdata),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty),
        .o_count   (w_tx_count)
    );

    always_comb begin
        w_next_state = r_state;
        w_rx_pop     = 1'b0;
        w_tx_push    = 1'b0;
        w_tx_wdata   = '0;
        w_fifo_clr   = 1'b0;
        w_acc_add    = 1'b0;
        w_start_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iCTL_START_MODE == MODE_COPY || iCTL_START_MODE == MODE_SWAP ||
                    iCTL_START_MODE == MODE_ACC) begin
                    w_start_run  = 1'b1;
                    w_next_state = ST_RUN;
                end else if (iCTL_START_MODE == MODE_CLEAR) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_RUN: begin
                // An empty RX simply stalls here; the packet may arrive at any later time.
                if (!w_rx_empty && !w_tx_full) begin
                    w_rx_pop = 1'b1;
                    if (r_mode == MODE_ACC) begin
                        w_acc_add = 1'b1;
                    end else begin
                        w_tx_push  = 1'b1;
                        w_tx_wdata = {w_rx_last, w_rx_keep,
                                      (r_mode == MODE_SWAP) ? swap_halves(w_rx_data) : w_rx_data};
                    end
                    if (w_rx_last) begin
                        w_next_state = (r_mode == MODE_ACC) ? ST_ACC_OUT : ST_IDLE;
                    end
                end
            end
            ST_ACC_OUT: begin
                if (!w_tx_full) begin
                    w_tx_push    = 1'b1;
                    w_tx_wdata   = {1'b1, {KEEP_W{1'b1}}, r_acc};
                    w_next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                w_fifo_clr   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_mode <= MODE_NONE;
            r_acc  <= '0;
        end else if (w_start_run) begin
            r_mode <= iCTL_START_MODE;
            r_acc  <= '0;
        end else if (w_acc_add) begin
            r_acc <= r_acc + w_rx_data;
        end
    end

    assign oS_AXIS_TREADY = w_s_ready;
    assign oM_AXIS_TVALID = ~w_tx_empty;
    assign oM_AXIS_TLAST  = w_tx_rdata[ENTRY_W-1];
    assign oM_AXIS_TKEEP  = w_tx_rdata[DATA_W +: KEEP_W];
    assign oM_AXIS_TDATA  = w_tx_rdata[DATA_W-1:0];
    assign oR_AXIS_DCNT   = 32'(w_rx_count);
    assign oW_AXIS_DCNT   = 32'(w_tx_count);
    assign oDBG_STATE     = r_state;

endmodule

// File: tb/tb_bdy_axis_engine.sv
// Bench for bdy_axis_engine: randomized packets against a queue-level command model,
// with a negedge scoreboard on the master stream and per-scenario checks.
module tb_bdy_axis_engine;
  import bdy_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_mode;
  logic        s_tvalid;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        m_tready;
  logic        o_s_tready;
  logic        o_m_tvalid;
  logic [63:0] o_m_tdata;
  logic [7:0]  o_m_tkeep;
  logic        o_m_tlast;
  logic [31:0] o_r_dcnt;
  logic [31:0] o_w_dcnt;
  logic [1:0]  o_dbg_state;

  int n_tests;
  int n_fail;

  logic [72:0] exp_q[$];
  logic [72:0] model_rx[$];
  bit          model_active;
  logic [2:0]  model_mode;
  logic [63:0] model_acc;

  bdy_axis_engine #(.FIFO_AW(5)) dut (
    .iSYS_CLK        (clk),
    .iSYS_RST        (rst_n),
    .iCTL_START_MODE (start_mode),
    .iS_AXIS_TVALID  (s_tvalid),
    .oS_AXIS_TREADY  (o_s_tready),
    .iS_AXIS_TDATA   (s_tdata),
    .iS_AXIS_TKEEP   (s_tkeep),
    .iS_AXIS_TLAST   (s_tlast),
    .oM_AXIS_TVALID  (o_m_tvalid),
    .iM_AXIS_TREADY  (m_tready),
    .oM_AXIS_TDATA   (o_m_tdata),
    .oM_AXIS_TKEEP   (o_m_tkeep),
    .oM_AXIS_TLAST   (o_m_tlast),
    .oR_AXIS_DCNT    (o_r_dcnt),
    .oW_AXIS_DCNT    (o_w_dcnt),
    .oDBG_STATE      (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog time_ns=%0t required=<500000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Reference model: consumes RX beats in order once a command is active.
  function automatic void model_run();
    logic [72:0] b;
    while (model_active && model_rx.size() > 0) begin
      b = model_rx.pop_front();
      if (model_mode == 3'd1) exp_q.push_back(b);
      else if (model_mode == 3'd2) exp_q.push_back({b[72:64], b[31:0], b[63:32]});
      else model_acc = model_acc + b[63:0];
      if (b[72]) begin
        if (model_mode == 3'd3) exp_q.push_back({1'b1, 8'hFF, model_acc});
        model_active = 1'b0;
      end
    end
  endfunction

  function automatic void model_add(input logic [72:0] b);
    model_rx.push_back(b);
    model_run();
  endfunction

  function automatic void model_start(input logic [2:0] m);
    if (model_active) return;
    if (m >= 3'd1 && m <= 3'd3) begin
      model_active = 1'b1;
      model_mode   = m;
      model_acc    = '0;
      model_run();
    end else if (m == 3'd4) begin
      model_rx.delete();
      exp_q.delete();
    end
  endfunction

  // scoreboard on the master stream; handshake sampled half a cycle before its edge
  always @(negedge clk) begin
    logic [72:0] got;
    logic [72:0] exp;
    if (rst_n && o_m_tvalid && m_tready) begin
      got = {o_m_tlast, o_m_tkeep, o_m_tdata};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected got=%h required=<no beat>", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL out_beat got=%h required=%h", got, exp);
        end
      end
    end
  end

  // driver tasks (entered and left at #1 after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int guard;
    guard    = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    while (!o_s_tready && guard < 300) begin
      tick();
      guard++;
    end
    if (!o_s_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout tready=%0b required=1", o_s_tready);
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic load(input int n, input bit last_at_end, input bit gaps);
    logic [72:0] b;
    for (int i = 0; i < n; i++) begin
      b = {(last_at_end && i == n - 1), 8'($urandom_range(0, 255)), $urandom, $urandom};
      model_add(b);
      send_beat(b[63:0], b[71:64], b[72]);
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic pulse_start(input logic [2:0] m);
    start_mode = m;
    tick();
    start_mode = 3'd0;
  endtask

  task automatic wait_drain(input bit rand_ready, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 600) begin
      if (rand_ready) m_tready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    m_tready = 1'b1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({o_s_tready, o_m_tvalid, o_m_tlast} !== 3'b000 || o_m_tdata !== 64'd0 || o_m_tkeep !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs ready/valid/last=%b data=%h keep=%h required=0", {o_s_tready, o_m_tvalid, o_m_tlast}, o_m_tdata, o_m_tkeep);
    end
    n_tests++;
    if (o_r_dcnt !== 32'd0 || o_w_dcnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_dcnt r=%0d w=%0d required=0", o_r_dcnt, o_w_dcnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (o_s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge got=%b required=0", o_s_tready);
    end
    tick();
    n_tests++;
    if (o_s_tready !== 1'b1 || o_dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge ready=%b state=%0d required=1/0", o_s_tready, o_dbg_state);
    end
  endtask

  task automatic test_acc();
    int k;
    m_tready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      model_add({(i == 10), 8'($urandom_range(0, 255)), 64'(i)});
      send_beat(64'(i), 8'($urandom_range(0, 255)), (i == 10));
    end
    n_tests++;
    if (o_r_dcnt !== 32'd10) begin
      n_fail++;
      $display("FAIL acc_rx_dcnt got=%0d required=10", o_r_dcnt);
    end
    pulse_start(MODE_ACC);
    model_start(MODE_ACC);
    k = 0;
    while (!o_m_tvalid && k < 60) begin
      tick();
      k++;
    end
    n_tests++;
    if (k != 11 || o_w_dcnt !== 32'd1) begin
      n_fail++;
      $display("FAIL acc_latency cycles=%0d tx_dcnt=%0d required=11/1", k, o_w_dcnt);
    end
    wait_drain(1'b0, "acc");
    n_tests++;
    if (o_r_dcnt !== 32'd0 || o_dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL acc_end rx_dcnt=%0d state=%0d required=0/0", o_r_dcnt, o_dbg_state);
    end
  endtask

  task automatic test_copy_bp();
    logic [63:0] first;
    m_tready = 1'b0;
    load(4, 1'b1, 1'b0);
    first = model_rx[0][63:0];
    pulse_start(MODE_COPY);
    model_start(MODE_COPY);
    tick();
    n_tests++;
    if (o_m_tvalid !== 1'b1 || o_m_tdata !== first) begin
      n_fail++;
      $display("FAIL copy_first valid=%b data=%h required=1/%h", o_m_tvalid, o_m_tdata, first);
    end
    wait_drain(1'b1, "copy_bp");
  endtask

  task automatic test_swap();
    m_tready = 1'b1;
    model_add({1'b1, 8'hA5, 64'h11111111_22222222});
    send_beat(64'h11111111_22222222, 8'hA5, 1'b1);
    pulse_start(MODE_SWAP);
    model_start(MODE_SWAP);
    wait_drain(1'b0, "swap");
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b1;
    load(3, 1'b1, 1'b0);
    load(2, 1'b1, 1'b0);
    pulse_start(MODE_COPY);
    model_start(MODE_COPY);
    tick();
    tick();
    n_tests++;
    if (o_dbg_state !== ST_RUN) begin
      n_fail++;
      $display("FAIL b2b_mid_state got=%0d required=%0d", o_dbg_state, ST_RUN);
    end
    tick();
    n_tests++;
    if (o_dbg_state !== ST_IDLE || o_r_dcnt !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_rate state=%0d rx_dcnt=%0d required=0/2", o_dbg_state, o_r_dcnt);
    end
    pulse_start(MODE_SWAP);
    model_start(MODE_SWAP);
    wait_drain(1'b0, "b2b");
  endtask

  task automatic test_full_rx();
    logic [72:0] b;
    m_tready = 1'b1;
    load(32, 1'b0, 1'b0);
    n_tests++;
    if (o_r_dcnt !== 32'd32 || o_s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rx dcnt=%0d ready=%b required=32/0", o_r_dcnt, o_s_tready);
    end
    b = {1'b1, 8'h0F, $urandom, $urandom};
    model_add(b);
    fork
      send_beat(b[63:0], b[71:64], 1'b1);
      begin
        repeat (4) tick();
        n_tests++;
        if (o_r_dcnt !== 32'd32 || o_s_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_hold dcnt=%0d ready=%b required=32/0", o_r_dcnt, o_s_tready);
        end
        pulse_start(MODE_COPY);
        model_start(MODE_COPY);
      end
    join
    wait_drain(1'b0, "full_rx");
    n_tests++;
    if (o_r_dcnt !== 32'd0) begin
      n_fail++;
      $display("FAIL full_end rx_dcnt=%0d required=0", o_r_dcnt);
    end
  endtask

  task automatic test_clear();
    m_tready = 1'b0;
    load(2, 1'b1, 1'b0);
    pulse_start(MODE_COPY);
    model_start(MODE_COPY);
    repeat (3) tick();
    load(5, 1'b0, 1'b0);
    n_tests++;
    if (o_w_dcnt !== 32'd2 || o_r_dcnt !== 32'd5) begin
      n_fail++;
      $display("FAIL clear_pre tx=%0d rx=%0d required=2/5", o_w_dcnt, o_r_dcnt);
    end
    pulse_start(MODE_CLEAR);
    model_start(MODE_CLEAR);
    n_tests++;
    if (o_s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_flush_ready got=%b required=0", o_s_tready);
    end
    tick();
    n_tests++;
    if (o_r_dcnt !== 32'd0 || o_w_dcnt !== 32'd0 || o_m_tvalid !== 1'b0 || o_dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL clear_post rx=%0d tx=%0d valid=%b state=%0d required=0/0/0/0", o_r_dcnt, o_w_dcnt, o_m_tvalid, o_dbg_state);
    end
    m_tready = 1'b1;
  endtask

  task automatic test_ignored_start();
    logic [72:0] b;
    m_tready = 1'b1;
    load(1, 1'b0, 1'b0);
    pulse_start(3'd6);
    model_start(3'd6);
    tick();
    n_tests++;
    if (o_dbg_state !== ST_IDLE || o_r_dcnt !== 32'd1 || o_w_dcnt !== 32'd0) begin
      n_fail++;
      $display("FAIL ignore_mode6 state=%0d rx=%0d tx=%0d required=0/1/0", o_dbg_state, o_r_dcnt, o_w_dcnt);
    end
    pulse_start(MODE_COPY);
    model_start(MODE_COPY);
    repeat (3) tick();
    pulse_start(MODE_CLEAR);
    model_start(MODE_CLEAR);
    pulse_start(MODE_SWAP);
    model_start(MODE_SWAP);
    n_tests++;
    if (o_dbg_state !== ST_RUN) begin
      n_fail++;
      $display("FAIL ignore_in_run state=%0d required=%0d", o_dbg_state, ST_RUN);
    end
    b = {1'b1, 8'h3C, $urandom, $urandom};
    model_add(b);
    send_beat(b[63:0], b[71:64], 1'b1);
    wait_drain(1'b0, "ignore");
    n_tests++;
    if (o_dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL ignore_end state=%0d required=0", o_dbg_state);
    end
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int it = 0; it < 10; it++) begin
      m_tready = 1'($urandom_range(0, 1));
      load($urandom_range(1, 6), 1'b1, 1'b1);
      m = 3'($urandom_range(1, 3));
      pulse_start(m);
      model_start(m);
      wait_drain(1'b1, "random");
      tick();
      n_tests++;
      if (o_dbg_state !== ST_IDLE || o_r_dcnt !== 32'd0 || o_w_dcnt !== 32'd0) begin
        n_fail++;
        $display("FAIL random_end iter=%0d state=%0d rx=%0d tx=%0d required=0/0/0", it, o_dbg_state, o_r_dcnt, o_w_dcnt);
      end
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    model_active = 1'b0;
    model_mode   = 3'd0;
    model_acc    = '0;
    rst_n        = 1'b0;
    start_mode   = 3'd0;
    s_tvalid     = 1'b0;
    s_tdata      = '0;
    s_tkeep      = '0;
    s_tlast      = 1'b0;
    m_tready     = 1'b1;
    test_reset();
    test_acc();
    test_copy_bp();
    test_swap();
    test_back_to_back();
    test_full_rx();
    test_clear();
    test_ignored_start();
    test_random();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bdy_axis_engine.md
# bdy_axis_engine

AXI4-Stream processing body that buffers an inbound 64-bit packet in an RX FIFO, applies a command selected by a start strobe, and emits the result through a TX FIFO. It sits between a DMA-style stream source/sink and the PS control register that drives the start mode. FIFO occupancies are exported for software polling.

## Interface
- FIFO_AW, default 5, FIFO address width; each FIFO holds 2^FIFO_AW = 32 entries.
- iSYS_CLK  in  1  single system clock, rising edge.
- iSYS_RST  in  1  reset, asynchronous assert, active-low.
- iCTL_START_MODE  in  3  command strobe; 0 = none; 1 COPY, 2 SWAP, 3 ACC, 4 CLEAR, 5-7 ignored.
- iS_AXIS_TVALID / oS_AXIS_TREADY / iS_AXIS_TDATA[63:0] / iS_AXIS_TKEEP[7:0] / iS_AXIS_TLAST: AXI-Stream slave input.
- oM_AXIS_TVALID / iM_AXIS_TREADY / oM_AXIS_TDATA[63:0] / oM_AXIS_TKEEP[7:0] / oM_AXIS_TLAST: AXI-Stream master output.
- oR_AXIS_DCNT  out  32  RX FIFO occupancy in words, zero-extended.
- oW_AXIS_DCNT  out  32  TX FIFO occupancy in words, zero-extended.

## Operation
- RX FIFO entry = {TLAST, TKEEP, TDATA} (73 bits); one entry is written on every cycle with TVALID & TREADY.
- oS_AXIS_TREADY = RX not full and FSM not in FLUSH.
- oM_AXIS_TVALID = TX not empty; TX head drives TDATA/TKEEP/TLAST; pop on TVALID & TREADY.
- FSM states: IDLE, RUN, ACC_OUT, FLUSH.
- IDLE: a nonzero iCTL_START_MODE of 1-3 latches the mode and moves to RUN; 4 moves to FLUSH; 5-7 and 0 are ignored. Start is ignored outside IDLE.
- RUN: on each cycle with RX not empty and TX not full, pop one RX entry and push one TX entry in the same edge.
  - COPY: data, keep, and last are unchanged.
  - SWAP: data = {d[31:0], d[63:32]}; keep and last are unchanged.
  - ACC: nothing is pushed; acc <= acc + d mod 2^64 (acc is cleared on entering RUN); keep is ignored.
- On popping an entry with TLAST=1: COPY/SWAP go to IDLE; ACC goes to ACC_OUT.
- If RX is empty in RUN, the FSM waits indefinitely and no timeout is applied.
- ACC_OUT: when TX is not full, push {last=1, keep=8'hFF, data=acc}, then go to IDLE.
- FLUSH: both FIFOs are reset to empty in one cycle, then the FSM returns to IDLE.
- Out-of-packet data is retained in the RX FIFO for the next command.

## Timing
- Reset values: all FIFO pointers and counts = 0, FSM = IDLE, acc = 0, oS_AXIS_TREADY = 0 during reset and 1 from the first edge after release, oM_AXIS_TVALID = 0, oM_AXIS_TDATA/TKEEP/TLAST = 0, DCNTs = 0.
- FIFOs are first-word-fall-through with registered occupancy. A write is visible in DCNT one cycle later.
- READY is based on the current full flag only. A full FIFO rejects a write even when a simultaneous pop occurs.
- Start sampled at edge N puts the FSM in RUN from N. The first pop/push is at edge N+1, and oM_AXIS_TVALID rises after N+1.
- Throughput is 1 word/cycle in RUN with an unstalled sink.
- ACC: the last pop occurs at edge L, the result is pushed at L+1, and oM_AXIS_TVALID is high after L+1.
- Simultaneous RX write and RUN pop in the same cycle is legal; the count is unchanged.
- Asynchronous reset mid-operation discards all contents immediately.

## Structure
- Shared package `bdy_pkg` holds:
  - the mode constants: MODE_NONE=0, COPY=1, SWAP=2, ACC=3, CLEAR=4;
  - the FSM state encoding;
  - the data, keep, and entry widths.
- Sub-module `bdy_axis_fifo`:
  - parameterized width and address width;
  - synchronous single-clock FWFT design;
  - full/empty/count outputs and a synchronous clear input.
  - It is instantiated twice, once as RX and once as TX.
- The top level contains the FSM, the datapath mux, and the accumulator.

## Test plan
- Reset: hold iSYS_RST low, then release -> all outputs 0, TREADY=1 after the first edge, DCNTs=0.
- ACC: stream 1..10 with TLAST on 10, then pulse mode 3 for one cycle -> TX gets a single word 64'd55 with TKEEP=FF and TLAST=1; oR_AXIS_DCNT returns to 0.
- COPY plus back-pressure:
  - Stream 4 words with TLAST on word 4 and pulse mode 1, toggling iM_AXIS_TREADY -> identical words come out in order, TLAST on the 4th, and none are lost.
  - SWAP: input 64'h11111111_22222222 -> output 64'h22222222_11111111.
- Full RX: push 33 words without starting -> TREADY drops after 32 words, oR_AXIS_DCNT=32, and the 33rd word is held until space frees.
- CLEAR and ignored starts:
  - Load 5 words, then pulse mode 4 -> both DCNTs=0 and TVALID=0.
  - Mode 6 -> no state change.
  - A start pulse while in RUN -> ignored.
